// File: rtl/mem_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_pkg : shared types for the memory-stage sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  function automatic logic [7:0] msize_mask(input msize_t msize);
    logic [7:0] mask;
    case (msize)
      MSIZE1:  mask = 8'h01;
      MSIZE2:  mask = 8'h03;
      MSIZE4:  mask = 8'h0F;
      MSIZE8:  mask = 8'hFF;
      default: mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_readdata.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_readdata : load lane extraction, extension, misalign check.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_ctrl_readdata
  import mem_access_ctrl_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  addr,
  input  msize_t      msize,
  input  logic        is_unsigned,
  output logic [63:0] rdata,
  output logic        load_misalign
);

  logic [63:0] shifted;

  always_comb begin
    shifted       = data >> {addr, 3'b000};
    rdata         = '0;
    load_misalign = 1'b0;
    case (msize)
      MSIZE1: rdata = is_unsigned ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
      MSIZE2: begin
        load_misalign = addr[0];
        rdata = is_unsigned ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      end
      MSIZE4: begin
        load_misalign = |addr[1:0];
        rdata = is_unsigned ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      end
      MSIZE8: begin
        load_misalign = |addr;
        rdata         = shifted;
      end
      default: load_misalign = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl_writedata.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_writedata : store lane placement, strobes, misalign check.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_ctrl_writedata
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]  addr,
  input  msize_t      msize,
  input  logic [63:0] wdata,
  output logic [7:0]  strobe,
  output logic [63:0] data,
  output logic        store_misalign
);

  always_comb begin
    strobe = msize_mask(msize) << addr;
    data   = wdata << {addr, 3'b000};
    case (msize)
      MSIZE1:  store_misalign = 1'b0;
      MSIZE2:  store_misalign = addr[0];
      MSIZE4:  store_misalign = |addr[1:0];
      MSIZE8:  store_misalign = |addr;
      default: store_misalign = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl : M-stage load/store sequencer driving the dbus handshake.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  input  logic        req_is_load,
  input  logic        req_is_store,
  input  logic [63:0] req_addr,
  input  msize_t      req_msize,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        load_misalign,
  output logic        store_misalign,
  input  logic        resp_ack,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp,
  output logic        bus_timeout
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  mem_state_t       state_q, state_d;
  logic [63:0]      addr_q, addr_d;
  msize_t           msize_q, msize_d;
  logic             unsigned_q, unsigned_d;
  logic [63:0]      wdata_q, wdata_d;
  logic             is_load_q, is_load_d;
  logic [63:0]      rdata_q, rdata_d;
  logic             load_mis_q, load_mis_d;
  logic             store_mis_q, store_mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_idle, in_done, bus_active;
  logic [2:0]       sel_addr;
  msize_t           sel_msize;
  logic [63:0]      rd_data, wr_data;
  logic             rd_misalign, wr_misalign;
  logic [7:0]       wr_strobe;
  logic [CNT_W-1:0] cnt_inc;
  logic             unused_addr_ok;

  assign in_idle        = (state_q == IDLE);
  assign in_done        = (state_q == DONE);
  assign bus_active     = (state_q == BUSY) || (state_q == DRAIN);
  assign unused_addr_ok = dresp.addr_ok;

  // In IDLE the helpers judge the incoming request; afterwards the latched op.
  assign sel_addr  = in_idle ? req_addr[2:0] : addr_q[2:0];
  assign sel_msize = in_idle ? req_msize     : msize_q;
  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  mem_access_ctrl_readdata u_readdata (
    .data          (dresp.data),
    .addr          (sel_addr),
    .msize         (sel_msize),
    .is_unsigned   (unsigned_q),
    .rdata         (rd_data),
    .load_misalign (rd_misalign)
  );

  mem_access_ctrl_writedata u_writedata (
    .addr           (sel_addr),
    .msize          (sel_msize),
    .wdata          (wdata_q),
    .strobe         (wr_strobe),
    .data           (wr_data),
    .store_misalign (wr_misalign)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    msize_d     = msize_q;
    unsigned_d  = unsigned_q;
    wdata_d     = wdata_q;
    is_load_d   = is_load_q;
    rdata_d     = rdata_q;
    load_mis_d  = load_mis_q;
    store_mis_d = store_mis_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          addr_d      = req_addr;
          msize_d     = req_msize;
          unsigned_d  = req_unsigned;
          wdata_d     = req_wdata;
          is_load_d   = req_is_load;
          rdata_d     = '0;
          load_mis_d  = req_is_load && rd_misalign;
          store_mis_d = req_is_store && wr_misalign;
          cnt_d       = '0;
          state_d     = (load_mis_d || store_mis_d) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_inc;
        if (dresp.data_ok) begin
          rdata_d = is_load_q ? rd_data : '0;
          state_d = flush ? IDLE : DONE;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (flush || resp_ack) state_d = IDLE;
      end
      DRAIN: begin
        cnt_d = cnt_inc;
        if (dresp.data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      msize_q     <= MSIZE1;
      unsigned_q  <= 1'b0;
      wdata_q     <= '0;
      is_load_q   <= 1'b0;
      rdata_q     <= '0;
      load_mis_q  <= 1'b0;
      store_mis_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      msize_q     <= msize_d;
      unsigned_q  <= unsigned_d;
      wdata_q     <= wdata_d;
      is_load_q   <= is_load_d;
      rdata_q     <= rdata_d;
      load_mis_q  <= load_mis_d;
      store_mis_q <= store_mis_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    req_ready      = in_idle && !flush && !reset;
    resp_valid     = in_done;
    resp_rdata     = in_done ? rdata_q : '0;
    load_misalign  = in_done && load_mis_q;
    store_misalign = in_done && store_mis_q;
    bus_timeout    = (TIMEOUT != 0) && bus_active && (cnt_q == CNT_MAX);
    dreq           = '0;
    if (bus_active) begin
      dreq.valid  = 1'b1;
      dreq.addr   = addr_q;
      dreq.size   = msize_q;
      dreq.strobe = is_load_q ? 8'h00 : wr_strobe;
      dreq.data   = is_load_q ? 64'd0 : wr_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl : directed and randomized checks of mem_access_ctrl.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, req_is_load, req_is_store, req_unsigned, resp_ack;
  logic [63:0] req_addr, req_wdata;
  msize_t      req_msize;
  logic        req_ready, resp_valid, load_misalign, store_misalign, bus_timeout;
  logic [63:0] resp_rdata;
  dbus_req_t   dreq;
  dbus_resp_t  dresp;

  int n_assert = 0;
  int n_fail   = 0;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_is_load    (req_is_load),
    .req_is_store   (req_is_store),
    .req_addr       (req_addr),
    .req_msize      (req_msize),
    .req_unsigned   (req_unsigned),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .load_misalign  (load_misalign),
    .store_misalign (store_misalign),
    .resp_ack       (resp_ack),
    .dreq           (dreq),
    .dresp          (dresp),
    .bus_timeout    (bus_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: plain byte arithmetic on the access size.
  function automatic int nbytes_of(input logic [2:0] m);
    return (m < 3'd4) ? (1 << m) : 0;
  endfunction

  function automatic bit is_mis(input logic [2:0] m, input logic [63:0] a);
    int nb;
    int off;
    nb  = nbytes_of(m);
    off = int'(a[2:0]);
    return (nb == 0) || ((off % nb) != 0);
  endfunction

  function automatic logic [63:0] exp_load(input logic [63:0] bd, input int off, input int nb, input bit uns);
    logic [63:0] v;
    logic [63:0] m;
    v = bd >> (8 * off);
    if (nb == 8) return v;
    m = (64'd1 << (8 * nb)) - 64'd1;
    v = v & m;
    if (!uns && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [7:0] exp_strobe(input int off, input int nb);
    logic [15:0] s;
    s = ((16'd1 << nb) - 16'd1) << off;
    return s[7:0];
  endfunction

  task automatic drive_req(input bit ld, input logic [63:0] a, input logic [2:0] msz,
                           input bit uns, input logic [63:0] wd);
    req_valid    = 1'b1;
    req_is_load  = ld;
    req_is_store = !ld;
    req_addr     = a;
    req_msize    = msize_t'(msz);
    req_unsigned = uns;
    req_wdata    = wd;
  endtask

  task automatic scramble_req();
    req_valid    = 1'b0;
    req_is_load  = 1'b0;
    req_is_store = 1'b0;
    req_addr     = {$urandom, $urandom};
    req_msize    = msize_t'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1));
    req_wdata    = {$urandom, $urandom};
  endtask

  // Full transaction: accept, bus phase of lat cycles (skipped if misaligned), ack after ackd cycles.
  task automatic run_op(input bit ld, input logic [63:0] a, input logic [2:0] msz, input bit uns,
                        input logic [63:0] wd, input int lat, input logic [63:0] bd, input int ackd);
    int nb;
    int off;
    bit mis;
    logic [63:0] e_rd;
    nb   = nbytes_of(msz);
    off  = int'(a[2:0]);
    mis  = is_mis(msz, a);
    e_rd = (ld && !mis) ? exp_load(bd, off, nb, uns) : 64'd0;
    drive_req(ld, a, msz, uns, wd);
    #1;
    check("accept_ready", 64'(req_ready), 64'd1);
    tick();
    scramble_req();
    if (!mis) begin
      for (int c = 1; c <= lat; c++) begin
        dresp.addr_ok = 1'($urandom_range(0, 1));
        dresp.data_ok = (c == lat);
        dresp.data    = (c == lat) ? bd : {$urandom, $urandom};
        #1;
        check("busy_dvalid", 64'(dreq.valid), 64'd1);
        check("busy_addr", dreq.addr, a);
        check("busy_size", 64'(dreq.size), 64'(msz));
        check("busy_strobe", 64'(dreq.strobe), ld ? 64'd0 : 64'(exp_strobe(off, nb)));
        if (!ld) check("busy_wdata", dreq.data, wd << (8 * off));
        check("busy_rvalid", 64'(resp_valid), 64'd0);
        check("busy_ready", 64'(req_ready), 64'd0);
        check("busy_timeout", 64'(bus_timeout), 64'((c - 1) >= TO));
        tick();
        dresp.data_ok = 1'b0;
        dresp.data    = {$urandom, $urandom};
      end
    end
    for (int d = 0; d <= ackd; d++) begin
      resp_ack = (d == ackd);
      #1;
      check("done_rvalid", 64'(resp_valid), 64'd1);
      check("done_rdata", resp_rdata, e_rd);
      check("done_lmis", 64'(load_misalign), 64'(ld && mis));
      check("done_smis", 64'(store_misalign), 64'(!ld && mis));
      check("done_ready", 64'(req_ready), 64'd0);
      check("done_dvalid", 64'(dreq.valid), 64'd0);
      check("done_timeout", 64'(bus_timeout), 64'd0);
      tick();
    end
    resp_ack = 1'b0;
  endtask

  // Aligned op flushed during its bus phase at cycle fc; data_ok at cycle lat (fc <= lat).
  task automatic run_flush(input bit ld, input logic [63:0] a, input logic [2:0] msz,
                           input int fc, input int lat);
    drive_req(ld, a, msz, 1'b0, {$urandom, $urandom});
    tick();
    scramble_req();
    for (int c = 1; c <= lat; c++) begin
      flush         = (c == fc);
      dresp.data_ok = (c == lat);
      dresp.data    = {$urandom, $urandom};
      #1;
      check("flush_dvalid", 64'(dreq.valid), 64'd1);
      check("flush_addr", dreq.addr, a);
      check("flush_rvalid", 64'(resp_valid), 64'd0);
      check("flush_ready", 64'(req_ready), 64'd0);
      check("flush_timeout", 64'(bus_timeout), 64'((c - 1) >= TO));
      tick();
    end
    flush         = 1'b0;
    dresp.data_ok = 1'b0;
    #1;
    check("flush_end_rvalid", 64'(resp_valid), 64'd0);
    check("flush_end_dvalid", 64'(dreq.valid), 64'd0);
    check("flush_end_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    bit ld;
    logic [2:0] msz;
    logic [63:0] a;

    reset = 1'b1;
    flush = 1'b0;
    resp_ack = 1'b0;
    dresp = '0;
    scramble_req();
    tick();
    tick();
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rvalid", 64'(resp_valid), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_lmis", 64'(load_misalign), 64'd0);
    check("rst_smis", 64'(store_misalign), 64'd0);
    check("rst_dvalid", 64'(dreq.valid), 64'd0);
    check("rst_timeout", 64'(bus_timeout), 64'd0);
    reset = 1'b0;
    tick();
    #1;
    check("idle_ready", 64'(req_ready), 64'd1);

    // LW sign-extended, SB lane placement, misaligned LD/SH, illegal sizes
    run_op(1'b1, 64'h1004, 3'd2, 1'b0, 64'd0, 3, 64'h8000_0001_1234_5678, 0);
    run_op(1'b0, 64'h2003, 3'd0, 1'b0, 64'hAB, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(1'b1, 64'h3004, 3'd3, 1'b0, 64'd0, 1, 64'd0, 0);
    run_op(1'b0, 64'h3001, 3'd1, 1'b0, 64'h1234, 1, 64'd0, 0);
    run_op(1'b1, 64'h4000, 3'd5, 1'b0, 64'd0, 1, 64'd0, 0);
    run_op(1'b0, 64'h4000, 3'd6, 1'b0, 64'd0, 1, 64'd0, 1);
    run_op(1'b1, 64'h5006, 3'd1, 1'b1, 64'd0, 1, 64'h9ABC_0000_0000_0000, 0);
    // Watchdog window and held-off acknowledge
    run_op(1'b1, 64'h6000, 3'd3, 1'b0, 64'd0, 10, 64'hDEAD_BEEF_0BAD_F00D, 0);
    run_op(1'b1, 64'h7001, 3'd0, 1'b0, 64'd0, 2, 64'h0000_0000_0000_8000, 3);

    // Flush while busy: drain case and same-cycle completion case
    run_flush(1'b1, 64'h8008, 3'd3, 2, 5);
    run_flush(1'b0, 64'h8010, 3'd2, 3, 3);
    run_flush(1'b1, 64'h8020, 3'd2, 1, 8);

    // Flush in IDLE beats req_valid
    drive_req(1'b1, 64'h9000, 3'd2, 1'b0, 64'd0);
    flush = 1'b1;
    #1;
    check("idle_flush_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    scramble_req();
    #1;
    check("idle_flush_dvalid", 64'(dreq.valid), 64'd0);
    check("idle_flush_rvalid", 64'(resp_valid), 64'd0);
    check("idle_flush_ready2", 64'(req_ready), 64'd1);

    // Flush in DONE drops the result; with and without resp_ack
    for (int k = 0; k < 2; k++) begin
      drive_req(1'b0, 64'h9002, 3'd2, 1'b0, 64'd7);
      tick();
      scramble_req();
      flush = 1'b1;
      resp_ack = (k == 1);
      #1;
      check("done_flush_rvalid", 64'(resp_valid), 64'd1);
      tick();
      flush = 1'b0;
      resp_ack = 1'b0;
      #1;
      check("done_flush_after", 64'(resp_valid), 64'd0);
      check("done_flush_ready", 64'(req_ready), 64'd1);
    end

    // Reset in the middle of a bus transaction
    drive_req(1'b0, 64'hA000, 3'd3, 1'b0, 64'h1122_3344_5566_7788);
    tick();
    scramble_req();
    tick();
    reset = 1'b1;
    #1;
    check("midrst_dvalid_pre", 64'(dreq.valid), 64'd1);
    check("midrst_ready", 64'(req_ready), 64'd0);
    tick();
    #1;
    check("midrst_dvalid", 64'(dreq.valid), 64'd0);
    check("midrst_rvalid", 64'(resp_valid), 64'd0);
    check("midrst_rdata", resp_rdata, 64'd0);
    check("midrst_timeout", 64'(bus_timeout), 64'd0);
    reset = 1'b0;
    tick();
    #1;
    check("midrst_ready2", 64'(req_ready), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      ld  = 1'($urandom_range(0, 1));
      msz = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) msz = 3'($urandom_range(4, 7));
      a = {$urandom, $urandom};
      if (msz < 3'd4 && $urandom_range(0, 3) != 0)
        a = a & ~((64'd1 << msz) - 64'd1);
      run_op(ld, a, msz, 1'($urandom_range(0, 1)), {$urandom, $urandom},
             int'($urandom_range(1, 7)), {$urandom, $urandom}, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
